pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter AW, default 5: program-counter width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 21: PC value loaded by reset.
REQ-003 The block SHALL have parameter EXC_VEC, default 0: PC value loaded on exception.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4 (legal range 2..16): number of return-address-stack entries.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 The block SHALL have port stall, input, 1: hold the PC and the RAS.
REQ-008 The block SHALL have port br_valid, input, 1: redirect to br_target.
REQ-009 The block SHALL have port br_target, input, AW: redirect destination.
REQ-010 The block SHALL have port call, input, 1: qualifies br_valid as a call; push the return address.
REQ-011 The block SHALL have port ret, input, 1: return; pop the RAS.
REQ-012 The block SHALL have port exc, input, 1: exception; redirect to EXC_VEC.
REQ-013 The block SHALL have port pc, output, AW: current fetch address, registered.
REQ-014 The block SHALL have port pc_valid, output, 1: pc is a valid fetch address.
REQ-015 The block SHALL have port ras_empty, output, 1: RAS holds 0 entries.
REQ-016 The block SHALL have port ras_full, output, 1: RAS holds RAS_DEPTH entries.
REQ-017 The block SHALL have port ret_underflow, output, 1: one-cycle pulse when ret is taken on an empty RAS.

Function
REQ-018 The block SHALL update pc on the rising clk edge as next_pc, selected by fixed priority: exc > br_valid > stall > ret > sequential.
REQ-019 On exc, the block SHALL set next_pc = EXC_VEC, flush the RAS (count=0) and ignore all other inputs in that cycle.
REQ-020 On br_valid with exc=0, the block SHALL set next_pc = br_target, regardless of stall.
REQ-021 When br_valid=1 and call=1, the block SHALL push (pc+1) mod 2^AW onto the RAS in the same edge.
REQ-022 call with br_valid=0 SHALL have no effect.
REQ-023 A push when the RAS is full SHALL discard the oldest entry, keep count at RAS_DEPTH and place the new entry on top (circular buffer).
REQ-024 On stall with exc=0 and br_valid=0, the block SHALL hold pc and leave the RAS unchanged; ret SHALL be ignored.
REQ-025 On ret (exc=0, br_valid=0, stall=0) with the RAS non-empty, the block SHALL set next_pc = top entry and pop one entry.
REQ-026 On ret with the RAS empty, the block SHALL set next_pc = (pc+1) mod 2^AW and assert ret_underflow for exactly the next cycle.
REQ-027 Otherwise the block SHALL set next_pc = (pc+1) mod 2^AW, wrapping from 2^AW-1 to 0.
REQ-028 When ret and br_valid are both asserted, br_valid SHALL win and ret SHALL not pop.
REQ-029 ras_empty and ras_full SHALL be registered flags that reflect the RAS count after the current edge.
REQ-030 While pc_valid=0, all control inputs SHALL be ignored.

Reset
REQ-031 Asserting rst_n low SHALL immediately, without a clock edge, set pc=RESET_PC, pc_valid=0, RAS count=0, ras_empty=1, ras_full=0 and ret_underflow=0.
REQ-032 On the first rising edge after rst_n deasserts, the block SHALL hold pc=RESET_PC and set pc_valid=1.
REQ-033 Normal PC update SHALL start from the second rising edge after rst_n deasserts.
REQ-034 Reset asserted mid-operation SHALL discard all RAS contents and any pending underflow pulse.

Verification (AW=5, RESET_PC=21, EXC_VEC=0, RAS_DEPTH=4)
REQ-035 Scenario 1: release reset, no inputs -> pc 21 (pc_valid=0), 21 (pc_valid=1), 22 ... 31, then 0 (wrap).
REQ-036 Scenario 2: at pc=10 pulse br_valid+call with br_target=3, then ret -> pc=3 with ras_empty=0, then pc=11 with ras_empty=1.
REQ-037 Scenario 3: five calls from pc 1,5,9,13,17 (each target = pc+3) -> ras_full=1 after the fourth call; the fifth call drops return address 2; four rets yield 18,14,10,6; a fifth ret gives pc+1 and ret_underflow=1 for one cycle.
REQ-038 Scenario 4: stall=1 with ret=1 for 3 cycles -> pc and RAS unchanged; then exc during stall -> pc=0 and ras_empty=1.
REQ-039 Scenario 5: drop rst_n asynchronously between edges with 2 RAS entries -> pc=21 and ras_empty=1 before the next edge; after release, ret -> ret_underflow=1.
REQ-040 Scenario 6: exc and br_valid asserted together with br_target=7 -> pc=0 and the RAS flushed.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the pipeline front end and the PC generator.
// The master drives redirect/stall controls; the slave returns the fetch PC and RAS status.
interface pc_gen_if #(
    parameter int unsigned AW = 5
);
    logic          stall;
    logic          br_valid;
    logic [AW-1:0] br_target;
    logic          call;
    logic          ret;
    logic          exc;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          ras_empty;
    logic          ras_full;
    logic          ret_underflow;

    modport master (
        output stall, br_valid, br_target, call, ret, exc,
        input  pc, pc_valid, ras_empty, ras_full, ret_underflow
    );

    modport slave (
        input  stall, br_valid, br_target, call, ret, exc,
        output pc, pc_valid, ras_empty, ras_full, ret_underflow
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator with a circular return-address stack.
// Priority of next-PC sources: exception > branch > stall > return > sequential.
module pc_gen #(
    parameter int unsigned AW        = 5,
    parameter int unsigned RESET_PC  = 21,
    parameter int unsigned EXC_VEC   = 0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_gen_if.slave  bus
);
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [AW-1:0] PC_RST   = AW'(RESET_PC);
    localparam logic [AW-1:0] PC_EXC   = AW'(EXC_VEC);
    localparam logic [PW-1:0] SP_LAST  = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [0:0]    state_q, state_n;
    logic [AW-1:0] pc_q, pc_n, pc_inc, ras_top;
    logic          pc_valid_q;
    logic          ras_empty_q, ras_full_q;
    logic          underflow_q, underflow_n;
    logic          push, pop, flush;
    logic [PW-1:0] sp_q, sp_n, sp_inc, sp_dec;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [AW-1:0] ras_mem [RAS_DEPTH];

    assign pc_inc  = pc_q + AW'(1);
    assign ras_top = ras_mem[sp_q];
    assign sp_inc  = (sp_q == SP_LAST) ? '0 : sp_q + PW'(1);
    assign sp_dec  = (sp_q == '0) ? SP_LAST : sp_q - PW'(1);

    // State register: BOOT holds the reset PC for one edge, RUN fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state, next-PC and RAS control selection.
    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        underflow_n = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_n = ST_RUN;
            end
            ST_RUN: begin
                if (bus.exc) begin
                    pc_n  = PC_EXC;
                    flush = 1'b1;
                end else if (bus.br_valid) begin
                    pc_n = bus.br_target;
                    push = bus.call;
                end else if (bus.stall) begin
                    pc_n = pc_q;
                end else if (bus.ret) begin
                    if (cnt_q != '0) begin
                        pc_n = ras_top;
                        pop  = 1'b1;
                    end else begin
                        pc_n        = pc_inc;
                        underflow_n = 1'b1;
                    end
                end else begin
                    pc_n = pc_inc;
                end
            end
            default: begin
                state_n = ST_BOOT;
            end
        endcase
    end

    // Stack pointer and occupancy; a push on a full stack overwrites the oldest slot.
    always_comb begin
        sp_n  = sp_q;
        cnt_n = cnt_q;
        if (flush) begin
            cnt_n = '0;
        end else if (push) begin
            sp_n  = sp_inc;
            cnt_n = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
        end else if (pop) begin
            sp_n  = sp_dec;
            cnt_n = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= PC_RST;
            pc_valid_q  <= 1'b0;
            sp_q        <= '0;
            cnt_q       <= '0;
            ras_empty_q <= 1'b1;
            ras_full_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_n;
            pc_valid_q  <= (state_n == ST_RUN);
            sp_q        <= sp_n;
            cnt_q       <= cnt_n;
            ras_empty_q <= (cnt_n == '0);
            ras_full_q  <= (cnt_n == CNT_FULL);
            underflow_q <= underflow_n;
        end
    end

    // Entries need no reset: validity is tracked entirely by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[sp_inc] <= pc_inc;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.ras_empty     = ras_empty_q;
    assign bus.ras_full      = ras_full_q;
    assign bus.ret_underflow = underflow_q;
endmodule
